// File: rtl/ofdm_framer_pkg.sv
// rtl/ofdm_framer_pkg.sv - shared slot types, sequencer states and slot classification helpers
package ofdm_framer_pkg;

    typedef enum logic [1:0] {
        DATA  = 2'd0,
        PILOT = 2'd1,
        SYNC  = 2'd2
    } slot_type_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_e;

    // Pilot polarity alternates every density subcarriers: +1 on even multiples.
    function automatic logic pilot_bit(input logic [31:0] subc, input logic [31:0] density);
        return (subc % (density << 1)) == 32'd0;
    endfunction

    function automatic slot_type_e classify_slot(input logic is_sync, input logic is_pilot);
        if (is_sync)
            return SYNC;
        if (is_pilot)
            return PILOT;
        return DATA;
    endfunction

endpackage

// File: rtl/ofdm_slot_counter.sv
// rtl/ofdm_slot_counter.sv - nested subcarrier/symbol counter with wrap flags and look-ahead outputs
module ofdm_slot_counter #(
    parameter int USED_CARRIERS     = 800,
    parameter int SYMBOLS_PER_FRAME = 10,
    parameter int CNT_W             = 10
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             clear,
    input  logic             advance,
    output logic [CNT_W-1:0] subc,
    output logic [CNT_W-1:0] symbol,
    output logic [CNT_W-1:0] next_subc,
    output logic [CNT_W-1:0] next_symbol,
    output logic             last_subc,
    output logic             last_slot
);

    assign last_subc = (subc == CNT_W'(USED_CARRIERS - 1));
    assign last_slot = last_subc && (symbol == CNT_W'(SYMBOLS_PER_FRAME - 1));

    always_comb begin
        next_subc   = subc;
        next_symbol = symbol;
        if (clear) begin
            next_subc   = '0;
            next_symbol = '0;
        end else if (advance) begin
            if (last_subc) begin
                next_subc   = '0;
                next_symbol = symbol + CNT_W'(1);
            end else begin
                next_subc   = subc + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            subc   <= '0;
            symbol <= '0;
        end else begin
            subc   <= next_subc;
            symbol <= next_symbol;
        end
    end

endmodule

// File: rtl/ofdm_frame_sequencer.sv
// rtl/ofdm_frame_sequencer.sv - per-slot control token generator; pilots gated by OFDM_SEQ_PILOT_EN
import ofdm_framer_pkg::*;

module ofdm_frame_sequencer #(
    parameter int SYMBOLS_PER_FRAME = 10,
    parameter int SYNC_SYMBOLS      = 1,
    parameter int USED_CARRIERS     = 800,
    parameter int PILOT_DENSITY     = 5,
    parameter int CNT_W             = 10
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     frame_start,
    input  logic                     frame_abort,
    input  logic [USED_CARRIERS-1:0] sync_word,
    output logic                     m_axis_ctrl_tvalid,
    input  logic                     m_axis_ctrl_tready,
    output logic                     m_axis_ctrl_tlast,
    output logic                     m_axis_ctrl_tuser,
    output logic [1:0]               ctrl_type,
    output logic                     ctrl_bit,
    output logic [CNT_W-1:0]         ctrl_subc,
    output logic [CNT_W-1:0]         ctrl_symbol,
    output logic                     busy,
    output logic                     frame_done,
    output logic [15:0]              frame_count
);

    seq_state_e       state;
    logic             fire, start_ok, last_done, adv, load;
    logic             last_subc, last_slot;
    logic [CNT_W-1:0] next_subc, next_symbol;
    logic             nxt_sync, nxt_pilot, nxt_pbit, nxt_sync_bit, nxt_tlast;
    slot_type_e       nxt_type;

    assign m_axis_ctrl_tvalid = (state == RUN);
    assign busy               = (state == RUN);

    assign fire      = m_axis_ctrl_tvalid & m_axis_ctrl_tready;
    assign start_ok  = (state == IDLE) & frame_start & ~frame_abort;
    assign last_done = fire & last_slot & ~frame_abort;
    assign adv       = fire & ~last_slot & ~frame_abort;
    assign load      = start_ok | adv;

    ofdm_slot_counter #(
        .USED_CARRIERS    (USED_CARRIERS),
        .SYMBOLS_PER_FRAME(SYMBOLS_PER_FRAME),
        .CNT_W            (CNT_W)
    ) u_cnt (
        .aclk       (aclk),
        .areset     (areset),
        .clear      (start_ok),
        .advance    (adv),
        .subc       (ctrl_subc),
        .symbol     (ctrl_symbol),
        .next_subc  (next_subc),
        .next_symbol(next_symbol),
        .last_subc  (last_subc),
        .last_slot  (last_slot)
    );

    // Token fields are computed from the counter's next value so they register alongside it.
    always_comb begin
        nxt_sync     = (next_symbol < CNT_W'(SYNC_SYMBOLS));
        nxt_sync_bit = 1'b0;
        for (int k = 0; k < USED_CARRIERS; k++)
            if (next_subc == CNT_W'(k))
                nxt_sync_bit = sync_word[k];
`ifdef OFDM_SEQ_PILOT_EN
        nxt_pilot = ((32'(next_subc) % 32'(PILOT_DENSITY)) == 32'd0);
        nxt_pbit  = pilot_bit(32'(next_subc), 32'(PILOT_DENSITY));
`else
        nxt_pilot = 1'b0;
        nxt_pbit  = 1'b0;
`endif
        nxt_type  = classify_slot(nxt_sync, nxt_pilot);
        nxt_tlast = ~start_ok & ~last_subc & (ctrl_subc == CNT_W'(USED_CARRIERS - 2));
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state       <= IDLE;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_done <= last_done;
            if (last_done)
                frame_count <= frame_count + 16'd1;
            case (state)
                IDLE:    if (start_ok) state <= RUN;
                RUN:     if (frame_abort || last_done) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            ctrl_type         <= 2'd0;
            ctrl_bit          <= 1'b0;
            m_axis_ctrl_tlast <= 1'b0;
            m_axis_ctrl_tuser <= 1'b0;
        end else if (load) begin
            ctrl_type         <= nxt_type;
            ctrl_bit          <= nxt_sync ? nxt_sync_bit : (nxt_pilot & nxt_pbit);
            m_axis_ctrl_tlast <= nxt_tlast;
            m_axis_ctrl_tuser <= start_ok;
        end
    end

endmodule

// File: doc/ofdm_frame_sequencer.md
# ofdm_frame_sequencer

Control-token generator for the OFDM framer datapath. Per frame it walks every (symbol, subcarrier) slot and emits one token per slot on an AXI-Stream-style control channel, classifying each slot as SYNC, PILOT or DATA and supplying the carrier bit for non-data slots. The data-insertion stage consumes these tokens to decide, per subcarrier, whether to pull a payload nibble or to insert a sync/pilot value. It sits between the framer's register interface (start/abort/status) and the data/pilot insertion datapath.

## Interface
- SYMBOLS_PER_FRAME, 10, total symbols per frame, including sync symbols; range 2..1023.
- SYNC_SYMBOLS, 1, leading sync symbols per frame; range 1..SYMBOLS_PER_FRAME-1.
- USED_CARRIERS, 800, subcarriers per symbol; range 2..1024; sets the sync_word width.
- PILOT_DENSITY, 5, pilot spacing in subcarriers; range ≥2.
- CNT_W, 10, width of the subcarrier and symbol counters; must satisfy 2^CNT_W ≥ max(USED_CARRIERS, SYMBOLS_PER_FRAME).
- aclk  in  1  sole clock; all logic is rising-edge.
- areset  in  1  asynchronous, active-high reset.
- frame_start  in  1  one-cycle pulse that starts one frame; honoured only in IDLE.
- frame_abort  in  1  one-cycle pulse that terminates the frame in progress.
- sync_word  in  USED_CARRIERS  sync bit per subcarrier; bit k belongs to subcarrier k. Must be held stable while busy.
- m_axis_ctrl_tvalid  out  1  token valid.
- m_axis_ctrl_tready  in  1  consumer ready.
- m_axis_ctrl_tlast  out  1  last subcarrier of the symbol.
- m_axis_ctrl_tuser  out  1  first token of the frame.
- ctrl_type  out  2  slot type: 0 = DATA, 1 = PILOT, 2 = SYNC; 3 is never driven.
- ctrl_bit  out  1  carrier bit: sync bit, pilot bit, or 0 for DATA.
- ctrl_subc  out  CNT_W  subcarrier index.
- ctrl_symbol  out  CNT_W  symbol index within the frame.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse after a frame completes normally.
- frame_count  out  16  count of completed frames; wraps at 0xFFFF.

## Operation
- States: IDLE, RUN.
  - IDLE → RUN on frame_start with frame_abort low. Counters load symbol = 0, subc = 0.
  - RUN → IDLE on the handshake of the last token, i.e. symbol = SYMBOLS_PER_FRAME-1 and subc = USED_CARRIERS-1.
  - RUN → IDLE on frame_abort.
- Handshake: a token transfers when tvalid and tready are both high.
  - On transfer, subc increments. At USED_CARRIERS-1, subc wraps to 0 and symbol increments.
  - Without a transfer, all token fields hold.
- Slot classification:
  - symbol < SYNC_SYMBOLS: SYNC, ctrl_bit = sync_word[subc].
  - Otherwise, subc % PILOT_DENSITY == 0: PILOT, ctrl_bit = 1 if subc % (2·PILOT_DENSITY) == 0, else 0.
  - Otherwise: DATA, ctrl_bit = 0.
- Flags: tlast = (subc == USED_CARRIERS-1). tuser = (symbol == 0 && subc == 0).
- Completion: frame_done pulses, and frame_count increments, in the cycle after the last handshake. frame_done is not pulsed on abort.
- Abort: tvalid drops in the next cycle even without a handshake. This is a deliberate exception to the AXI valid-hold rule; the consumer flushes its partial symbol. frame_count is unchanged.
- Simultaneous events:
  - frame_start and frame_abort together in IDLE: abort wins and the frame does not start.
  - frame_start in RUN: ignored.
  - frame_start in the cycle frame_done pulses: accepted, because the state is already IDLE.
- Reset (async, mid-frame included): state = IDLE; all outputs 0, including tvalid, busy, frame_done, frame_count and every ctrl field.

## Timing
- frame_start at edge N → tvalid high, with the first token (tuser = 1) registered, after edge N+1.
- Sustained throughput is one token per cycle while tready is high; there are no bubbles across symbol boundaries.
- Tokens per frame = SYMBOLS_PER_FRAME × USED_CARRIERS.
- Back-to-back frames need at least one IDLE cycle.
- All outputs are registered. tvalid has no combinational path from tready.

## Configuration
- OFDM_SEQ_PILOT_EN defined: PILOT slots are generated as described in Operation.
- OFDM_SEQ_PILOT_EN undefined: every non-sync slot is DATA with ctrl_bit = 0, and the pilot modulo logic is not compiled.
- Counters, handshake and sync behaviour are identical in both builds.

## Structure
- Package ofdm_framer_pkg holds:
  - slot_type_e (DATA = 2'd0, PILOT = 2'd1, SYNC = 2'd2);
  - seq_state_e (IDLE, RUN);
  - the pilot-bit and classification function shared with the insertion datapath.
- Sub-module ofdm_slot_counter: nested subc/symbol counter with advance, clear and wrap flags (last_subc, last_slot).
- The top level holds the FSM, classification, output registers and status.

## Test plan
Bench parameters: USED_CARRIERS = 10, PILOT_DENSITY = 5, SYMBOLS_PER_FRAME = 3, SYNC_SYMBOLS = 1, sync_word = 10'b1011001110, tready held high.

1. frame_start → 30 tokens:
   - tokens 0–9 are SYNC with ctrl_bit matching sync_word bits 0–9;
   - subc 0 is PILOT bit 1 and subc 5 is PILOT bit 0 in symbols 1–2;
   - tlast on subc 9;
   - frame_done one cycle after token 29; frame_count = 1.
2. Random tready (50%) → same 30-token sequence, with fields stable while tvalid high and tready low.
3. frame_abort after 13 handshakes → tvalid low next cycle, busy low, no frame_done, frame_count unchanged; the next frame_start restarts at symbol 0, subc 0 with tuser = 1.
4. frame_start and frame_abort in the same IDLE cycle → no tokens, busy stays 0. frame_start at token 5 of a running frame → ignored, exactly 30 tokens.
5. areset asserted at token 17 → all outputs 0 asynchronously, without waiting for a clock edge; after release, frame_start produces a full 30-token frame.
6. OFDM_SEQ_PILOT_EN undefined → symbols 1–2 are all DATA with ctrl_bit = 0; the SYNC symbol is unchanged.
